// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_pkg
// Description : Shared types and constants for the CPU data-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAM  = 2'd1,
    ST_IO   = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  localparam logic [3:0]  REGION_RAM = 4'h0;
  localparam logic [3:0]  REGION_IO  = 4'h1;

  // Read data handed back on an unmapped or aborted read.
  localparam logic [31:0] ERR_RDATA  = 32'h0;

endpackage
`default_nettype wire

// File: rtl/dbus_decode.sv
`default_nettype none
// ============================================================================
// Module      : dbus_decode
// Description : Maps the top address nibble to a RAM / IO / unmapped select.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_decode
  import dbus_pkg::*;
(
  input  logic [3:0] region,
  output logic       sel_ram,
  output logic       sel_io
);

  always_comb begin
    sel_ram = 1'b0;
    sel_io  = 1'b0;
    if (region == REGION_RAM) begin
      sel_ram = 1'b1;
    end else if (region == REGION_IO) begin
      sel_io = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dbus_bridge
// Description : CPU data-port bridge to on-chip RAM and memory-mapped I/O,
//               with wait-state generation and unmapped-access reporting.
//               Optional I/O timeout abort enabled by DBUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int RAM_AW     = 12,
  parameter int RAM_WAIT   = 1,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_stb,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              bus_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_stb,
  output logic              io_we,
  output logic [27:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
);

  localparam logic [3:0] c_ram_wait = 4'(RAM_WAIT);

  state_e     r_state;
  logic [3:0] r_wcnt;
  logic       w_sel_ram;
  logic       w_sel_io;

  dbus_decode u_decode (
    .region  (cpu_addr[31:28]),
    .sel_ram (w_sel_ram),
    .sel_io  (w_sel_io)
  );

`ifdef DBUS_TIMEOUT_EN
  localparam logic [7:0] c_io_timeout = 8'(IO_TIMEOUT);

  logic [7:0] r_tcnt;
  logic       w_io_expire;

  // Fires in the IO cycle whose count increment would reach the limit.
  assign w_io_expire = ((r_tcnt + 8'd1) == c_io_timeout);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_wcnt    <= 4'd0;
      cpu_rdata <= 32'h0;
      cpu_ack   <= 1'b0;
      bus_err   <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      io_stb    <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= 28'h0;
      io_wdata  <= 32'h0;
`ifdef DBUS_TIMEOUT_EN
      r_tcnt    <= 8'd0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      bus_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (cpu_stb) begin
            if (w_sel_ram) begin
              r_state   <= ST_RAM;
              r_wcnt    <= c_ram_wait;
              ram_en    <= 1'b1;
              ram_we    <= cpu_we;
              ram_addr  <= cpu_addr[RAM_AW+1:2];
              ram_wdata <= cpu_wdata;
            end else if (w_sel_io) begin
              r_state  <= ST_IO;
              io_stb   <= 1'b1;
              io_we    <= cpu_we;
              io_addr  <= cpu_addr[27:0];
              io_wdata <= cpu_wdata;
`ifdef DBUS_TIMEOUT_EN
              r_tcnt   <= 8'd0;
`endif
            end else begin
              // Unmapped: no slave is touched, error completes next cycle.
              r_state <= ST_ACK;
              cpu_ack <= 1'b1;
              bus_err <= 1'b1;
              if (!cpu_we) begin
                cpu_rdata <= ERR_RDATA;
              end
            end
          end
        end

        ST_RAM: begin
          if (r_wcnt != 4'd0) begin
            r_wcnt <= r_wcnt - 4'd1;
          end else begin
            if (!ram_we) begin
              cpu_rdata <= ram_rdata;
            end
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            r_state <= ST_ACK;
            cpu_ack <= 1'b1;
          end
        end

        ST_IO: begin
          if (io_ack) begin
            if (!io_we) begin
              cpu_rdata <= io_rdata;
            end
            io_stb  <= 1'b0;
            io_we   <= 1'b0;
            r_state <= ST_ACK;
            cpu_ack <= 1'b1;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (w_io_expire) begin
            if (!io_we) begin
              cpu_rdata <= ERR_RDATA;
            end
            io_stb  <= 1'b0;
            io_we   <= 1'b0;
            r_state <= ST_ACK;
            cpu_ack <= 1'b1;
            bus_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
`endif
        end

        ST_ACK: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_bridge
// Description : Self-checking bench for dbus_bridge (directed table, random
//               accesses against a reference model, reset/back-to-back cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_bridge;

  localparam int RAM_WAIT = 1;
  localparam int IO_T     = 8;
`ifdef DBUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] io_rdata;
    int          io_ack;      // cycle index of the io_ack pulse, -1 = none
    int          exp_ack;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          ack, en, wen, stb;
    logic        err, is_ram, is_io, we;
    logic [31:0] rdata, wdata;
    logic [11:0] ram_addr;
    logic [27:0] io_addr;
  } exp_t;

  typedef struct {
    int          ack_cyc, en_cnt, we_cnt, stb_cnt, ack_cnt;
    logic        err, stray, io_we;
    logic [31:0] rdata, ram_wdata, io_wdata;
    logic [11:0] ram_addr;
    logic [27:0] io_addr;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_stb, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, bus_err;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        io_stb, io_we;
  logic [27:0] io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_ack;

  int          n_vec, n_miss;
  logic [31:0] model_rdata;
  logic [31:0] model_mem [int];
  logic [31:0] ram_mem [4096] = '{default: 32'h0};

  always #5 clk = ~clk;

  dbus_bridge #(.RAM_AW(12), .RAM_WAIT(RAM_WAIT), .IO_TIMEOUT(IO_T)) dut (
    .clk(clk), .reset(reset),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .bus_err(bus_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .io_stb(io_stb), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack)
  );

  // Environment RAM: synchronous write, asynchronous read.
  always @(posedge clk) if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_mem[ram_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic predict(input vec_t v, output exp_t e);
    logic [11:0] idx;
    e = '{default: 0};
    idx = v.addr[13:2];
    e.we = v.we; e.wdata = v.wdata; e.ram_addr = idx; e.io_addr = v.addr[27:0];
    case (v.addr[31:28])
      4'h0: begin
        e.is_ram = 1'b1; e.ack = RAM_WAIT + 2; e.en = RAM_WAIT + 1;
        e.wen = v.we ? RAM_WAIT + 1 : 0;
        if (v.we) model_mem[int'(idx)] = v.wdata;
        else model_rdata = model_mem.exists(int'(idx)) ? model_mem[int'(idx)] : 32'h0;
      end
      4'h1: begin
        e.is_io = 1'b1;
        if (TO_EN && (v.io_ack < 1 || v.io_ack > IO_T)) begin
          e.ack = IO_T + 1; e.stb = IO_T; e.err = 1'b1;
          if (!v.we) model_rdata = 32'h0;
        end else begin
          e.ack = v.io_ack + 1; e.stb = v.io_ack;
          if (!v.we) model_rdata = v.io_rdata;
        end
      end
      default: begin
        e.ack = 1; e.err = 1'b1;
        if (!v.we) model_rdata = 32'h0;
      end
    endcase
    e.rdata = model_rdata;
  endtask

  // Entered and left just after a rising edge; samples on falling edges.
  task automatic run_access(input vec_t v, output obs_t o);
    o = '{default: 0};
    o.ack_cyc = -1;
    cpu_stb = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    io_rdata = v.io_rdata;
    io_ack = (v.io_ack == 0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ram_en) begin
        o.en_cnt++;
        if (ram_we) o.we_cnt++;
        o.ram_addr = ram_addr; o.ram_wdata = ram_wdata;
      end
      if (io_stb) begin
        o.stb_cnt++;
        o.io_addr = io_addr; o.io_wdata = io_wdata; o.io_we = io_we;
      end
      if (cpu_ack) begin
        o.ack_cnt++;
        o.ack_cyc = c; o.err = bus_err; o.rdata = cpu_rdata;
      end
      @(posedge clk); #1;
      if (o.ack_cyc >= 0) break;
      cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      io_ack = (v.io_ack == c + 1);
    end
    cpu_stb = 1'b0; io_ack = 1'b0;
    @(negedge clk);
    o.stray = cpu_ack | ram_en | io_stb;
    @(posedge clk); #1;
  endtask

  task automatic compare(input string tag, input obs_t o, input exp_t e);
    check({tag, ".ack_cycle"}, o.ack_cyc, e.ack);
    check({tag, ".bus_err"},   {31'h0, o.err}, {31'h0, e.err});
    check({tag, ".rdata"},     o.rdata, e.rdata);
    check({tag, ".ram_en_cycles"}, o.en_cnt, e.en);
    check({tag, ".ram_we_cycles"}, o.we_cnt, e.wen);
    check({tag, ".io_stb_cycles"}, o.stb_cnt, e.stb);
    check({tag, ".stray"},     {31'h0, o.stray}, 32'h0);
    if (e.is_ram) begin
      check({tag, ".ram_addr"},  {20'h0, o.ram_addr}, {20'h0, e.ram_addr});
      check({tag, ".ram_wdata"}, o.ram_wdata, e.wdata);
    end
    if (e.is_io) begin
      check({tag, ".io_addr"},  {4'h0, o.io_addr}, {4'h0, e.io_addr});
      check({tag, ".io_wdata"}, o.io_wdata, e.wdata);
      check({tag, ".io_we"},    {31'h0, o.io_we}, {31'h0, e.we});
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".ctrl"}, {26'h0, cpu_ack, bus_err, ram_en, ram_we, io_stb, io_we}, 32'h0);
    check({tag, ".cpu_rdata"}, cpu_rdata, 32'h0);
    check({tag, ".ram_addr"},  {20'h0, ram_addr}, 32'h0);
    check({tag, ".ram_wdata"}, ram_wdata, 32'h0);
    check({tag, ".io_addr"},   {4'h0, io_addr}, 32'h0);
    check({tag, ".io_wdata"},  io_wdata, 32'h0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    exp_t e;
    obs_t o;
    int   acks, errs;

    n_vec = 0; n_miss = 0; model_rdata = 32'h0;
    reset = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    io_rdata = 32'h0; io_ack = 1'b0;

    //         we    addr           wdata          io_rdata      ioack ack err rdata
    tbl.push_back('{1'b1, 32'h0000_0010, 32'h0000_1234, 32'h0,         -1, 3, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'h0,         -1, 3, 1'b0, 32'h0000_1234});
    tbl.push_back('{1'b1, 32'h1000_0000, 32'h0000_1234, 32'h0,          5, 6, 1'b0, 32'h0000_1234});
    tbl.push_back('{1'b0, 32'h2000_0000, 32'h0,         32'h0,         -1, 1, 1'b1, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h1000_0040, 32'h0,         32'hCAFE_0001,  2, 3, 1'b0, 32'hCAFE_0001});
    tbl.push_back('{1'b1, 32'h0000_3FFC, 32'hA5A5_5A5A, 32'h0,          1, 3, 1'b0, 32'hCAFE_0001});
    tbl.push_back('{1'b0, 32'h0000_3FFC, 32'h0,         32'h0,         -1, 3, 1'b0, 32'hA5A5_5A5A});
    tbl.push_back('{1'b1, 32'hF000_0000, 32'h5555_AAAA, 32'h0,         -1, 1, 1'b1, 32'hA5A5_5A5A});
    tbl.push_back('{1'b0, 32'h0ABC_0010, 32'h0,         32'h0,         -1, 3, 1'b0, 32'h0000_1234});
    tbl.push_back('{1'b0, 32'h1FFF_FFFC, 32'h0,         32'h0BAD_F00D,  1, 2, 1'b0, 32'h0BAD_F00D});
`ifdef DBUS_TIMEOUT_EN
    tbl.push_back('{1'b0, 32'h1000_0100, 32'h0,         32'hDEAD_BEEF, -1, 9, 1'b1, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h1000_0104, 32'h0,         32'h1357_9BDF,  8, 9, 1'b0, 32'h1357_9BDF});
`endif

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      v = tbl[i];
      predict(v, e);
      run_access(v, o);
      check($sformatf("tbl%0d.ack_cycle", i), o.ack_cyc, v.exp_ack);
      check($sformatf("tbl%0d.bus_err", i), {31'h0, o.err}, {31'h0, v.exp_err});
      check($sformatf("tbl%0d.rdata", i), o.rdata, v.exp_rdata);
      compare($sformatf("tbl%0d", i), o, e);
    end

    // Reset in the middle of a RAM wait state.
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    @(negedge clk);
    @(posedge clk); #1;
    check("rst_mid.ram_en_before", {31'h0, ram_en}, 32'h1);
    #3 reset = 1'b0;
    #1 check_outputs_zero("rst_mid");
    cpu_stb = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    check("rst_mid.no_ack_after", acks, 0);
    model_rdata = 32'h0;
    @(posedge clk); #1;

    // Held strobe on an unmapped address: one new request every two cycles.
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2000_0000;
    acks = 0; errs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
      if (bus_err) errs++;
      @(posedge clk); #1;
    end
    cpu_stb = 1'b0;
    check("b2b.ack_count", acks, 4);
    check("b2b.err_count", errs, 4);
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      v.we = 1'($urandom); v.wdata = $urandom; v.io_rdata = $urandom;
      v.exp_ack = 0; v.exp_err = 1'b0; v.exp_rdata = 32'h0;
      if (r < 5) begin
        v.addr = {4'h0, 14'($urandom), 7'd0, 5'($urandom), 2'($urandom)};
        v.io_ack = $urandom_range(0, 4);
      end else if (r < 8) begin
        v.addr = {4'h1, 28'($urandom)};
        v.io_ack = $urandom_range(1, 12);
      end else begin
        v.addr = {4'($urandom_range(2, 15)), 28'($urandom)};
        v.io_ack = $urandom_range(0, 2);
      end
      predict(v, e);
      run_access(v, o);
      compare($sformatf("rnd%0d", i), o, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbus_bridge.md
# dbus_bridge

Data-bus bridge that sits directly downstream of the CPU's data port (`STB`/`WE`/`Addr`/`Data_O` in, `Data_I`/`ACK` out). It decodes each CPU access by address region, runs the access against either the on-chip data RAM or the memory-mapped I/O bus, and returns exactly one `ACK` per access. It generates the wait states the CPU stalls on and reports accesses to unmapped regions.

## Interface
Parameters:
- `RAM_AW`, 12: RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- `RAM_WAIT`, 1: extra RAM-state cycles before read data is captured; 0..15.
- `IO_TIMEOUT`, 255: I/O cycles allowed before abort (only with `DBUS_TIMEOUT_EN`); 1..255.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_stb`  in  1  CPU request strobe; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address; bits [1:0] ignored.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  read data; valid while `cpu_ack` = 1.
- `cpu_ack`  out  1  single-cycle completion pulse.
- `bus_err`  out  1  pulses together with `cpu_ack` on an unmapped or timed-out access.
- `ram_en`, `ram_we`  out  1  RAM enable and write enable.
- `ram_addr`  out  RAM_AW  word address, `cpu_addr[RAM_AW+1:2]`.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data; valid in the last RAM-state cycle.
- `io_stb`, `io_we`  out  1  I/O strobe and write enable; held until `io_ack`.
- `io_addr`  out  28  `cpu_addr[27:0]`.
- `io_wdata`  out  32  I/O write data.
- `io_rdata`  in  32  I/O read data; sampled when `io_ack` = 1.
- `io_ack`  in  1  I/O completion.

## Operation
- Region decode on `cpu_addr[31:28]`:
  - 4'h0 selects RAM.
  - 4'h1 selects I/O.
  - Any other value is unmapped.
- The request is registered in IDLE when `cpu_stb` = 1. Address, write data and `we` are latched, so CPU inputs are don't-care afterwards.
- FSM states are IDLE, RAM, IO, ACK.
  - IDLE, `cpu_stb`, RAM region: go to RAM and load `wcnt` = RAM_WAIT.
  - IDLE, `cpu_stb`, I/O region: go to IO and clear `tcnt`.
  - IDLE, `cpu_stb`, unmapped: go to ACK with error flag set. Read data is 32'h0 and no slave sees the access.
  - RAM: `ram_en` = 1 and `ram_we` = latched `we` on every RAM cycle. If `wcnt` != 0, decrement it. If `wcnt` = 0, capture `ram_rdata` (reads only) and go to ACK.
  - IO: `io_stb` = 1. When `io_ack` = 1, capture `io_rdata` (reads only) and go to ACK.
  - ACK: `cpu_ack` = 1 and `bus_err` = error flag, for one cycle. Then go to IDLE and clear the error flag.
- `cpu_rdata` is a register holding the last captured read; a write does not change it.
- A `cpu_stb` still high in the cycle after ACK is treated as a new request. Back-to-back accesses are legal.
- `io_ack` outside the IO state is ignored.

## Timing
- Reset (async, `reset` = 0): state IDLE, and all outputs are 0 (`cpu_ack`, `bus_err`, `cpu_rdata`, `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, `io_stb`, `io_we`, `io_addr`, `io_wdata`).
- Reset mid-access aborts the access immediately with no `cpu_ack`.
- With `cpu_stb` first high in cycle 0, `cpu_ack` is high in:
  - RAM access: cycle RAM_WAIT+2.
  - Unmapped access: cycle 1.
  - I/O access: the cycle after the cycle in which `io_ack` is sampled high.
- `io_stb` rises in cycle 1 and falls in the cycle after `io_ack`.
- `ram_en` is high for exactly RAM_WAIT+1 cycles per access.

## Configuration
- `DBUS_TIMEOUT_EN` defined:
  - `tcnt` (8-bit) increments on every IO cycle without `io_ack`.
  - When `tcnt` reaches IO_TIMEOUT, drop `io_stb`, go to ACK with the error flag set, and return read data 32'h0.
  - If `io_ack` arrives in the same cycle the timeout would fire, `io_ack` wins and there is no error.
- `DBUS_TIMEOUT_EN` undefined: IO waits indefinitely for `io_ack`, and `bus_err` fires only on unmapped accesses.

## Structure
- Package `dbus_pkg` holds:
  - The state enum.
  - `REGION_RAM` = 4'h0 and `REGION_IO` = 4'h1.
  - The read-data value returned on error (32'h0).
- One combinational sub-module, `dbus_decode`, maps `cpu_addr[31:28]` to a region select (RAM, IO or unmapped). The FSM, counters and registers live in `dbus_bridge`.

## Test plan
- RAM write, RAM_WAIT=1: STB with WE=1, addr 32'h0000_0010, data 32'h0000_1234 -> `ram_addr` = 4, `ram_we` high for 2 cycles, `cpu_ack` in cycle 3, `bus_err` = 0.
- RAM read-back of the same address -> `cpu_rdata` = 32'h0000_1234 with `cpu_ack` in cycle 3.
- I/O write: addr 32'h1000_0000, data 32'h0000_1234, slave acks 4 cycles after `io_stb` -> `io_addr` = 0, `io_wdata` = 32'h1234, `cpu_ack` one cycle after `io_ack`.
- Unmapped read at 32'h2000_0000 -> `cpu_ack` and `bus_err` both high in cycle 1, `cpu_rdata` = 0, `ram_en` and `io_stb` never asserted.
- I/O timeout (macro on, IO_TIMEOUT=8, slave silent) -> `io_stb` drops and `cpu_ack` + `bus_err` pulse. Repeat with `io_ack` on the expiry cycle -> no `bus_err`.
- Reset asserted during RAM wait -> all outputs 0 immediately, and no `cpu_ack` after release.
